// File: rtl/pwm_ctrl_pkg.sv
//-----------------------------------------------------------------------------
// pwm_ctrl_pkg
// Shared types and default sizes for the PWM duty ramp sequencer.
//   ramp_state_t : sequencer state (IDLE, RAMP_UP, RAMP_DN)
//   DUTY_W_DEF   : default duty word width, equal to the PWM 'value' width
//   DIV_W_DEF    : default width of the step-period divider
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } ramp_state_t;

    localparam int DUTY_W_DEF = 4;
    localparam int DIV_W_DEF  = 16;

endpackage : pwm_ctrl_pkg

// File: rtl/step_tick_gen.sv
//-----------------------------------------------------------------------------
// step_tick_gen
// Free-running step-period counter. The count advances every clock and
// returns to zero on the cycle it equals 'div', so 'tick' is high once every
// div+1 cycles. 'clr' holds the count at zero; the first tick after 'clr'
// drops therefore arrives div+1 edges after the last cleared edge.
// Ports:
//   clk  in  1      system clock, rising edge
//   rst  in  1      asynchronous active-high reset
//   clr  in  1      synchronous clear of the count
//   div  in  DIV_W  period minus one (all-ones gives 2^DIV_W cycles)
//   tick out 1      high while count == div
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module step_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             tick_s;

    // Equality compare only, so an all-ones divider never needs a wider count.
    always_comb begin
        tick_s = (cnt_q == div);
        if (clr) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (tick_s) begin
            cnt_d = {DIV_W{1'b0}};
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = tick_s;

endmodule : step_tick_gen

// File: rtl/pwm_ramp_ctrl.sv
//-----------------------------------------------------------------------------
// pwm_ramp_ctrl
// Drives the duty word of a PWM block. A start request (taken only in IDLE)
// latches target, step period, breathe mode and the current duty as origin,
// then steps duty one LSB per step period toward the target. In breathe mode
// the endpoints are swapped at each arrival and the ramp bounces until abort.
// Ports:
//   clk       in  1       system clock, rising edge
//   rst       in  1       asynchronous active-high reset
//   start     in  1       ramp request, sampled in IDLE only
//   abort     in  1       return to IDLE from any state, duty holds
//   breathe   in  1       bounce between origin and target (latched at start)
//   target    in  DUTY_W  ramp end value (latched at start)
//   step_div  in  DIV_W   step period minus one (latched at start)
//   duty      out DUTY_W  registered duty word for the PWM 'value' input
//   busy      out 1       registered, high while not IDLE
//   done      out 1       registered one-cycle pulse on reaching an endpoint
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              breathe,
    input  logic [DUTY_W-1:0] target,
    input  logic [DIV_W-1:0]  step_div,
    output logic [DUTY_W-1:0] duty,
    output logic              busy,
    output logic              done
);

    ramp_state_t       state_q, state_d;
    logic [DUTY_W-1:0] duty_q,  duty_d;
    logic [DUTY_W-1:0] tgt_q,   tgt_d;
    logic [DUTY_W-1:0] org_q,   org_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic              brth_q,  brth_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic              tick_s;
    logic              clr_s;
    logic [DUTY_W-1:0] duty_up_s;
    logic [DUTY_W-1:0] duty_dn_s;

    // The counter is held at zero whenever no ramp runs (or one is being
    // aborted), so the start edge leaves it at zero and the first step lands
    // div_q+1 edges later.
    assign clr_s = (state_q == IDLE) || abort;

    step_tick_gen #(
        .DIV_W (DIV_W)
    ) u_step_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .div  (div_q),
        .tick (tick_s)
    );

    // Stepping stops at the endpoint, so these never wrap when used.
    assign duty_up_s = duty_q + DUTY_W'(1);
    assign duty_dn_s = duty_q - DUTY_W'(1);

    // Next-state, duty stepping and endpoint handling.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        org_d   = org_q;
        div_d   = div_q;
        brth_d  = brth_q;
        done_d  = 1'b0;

        if (abort) begin
            // Abort beats start and suppresses any endpoint pulse.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tgt_d  = target;
                        div_d  = step_div;
                        brth_d = breathe;
                        org_d  = duty_q;
                        if (target > duty_q) begin
                            state_d = RAMP_UP;
                        end else if (target < duty_q) begin
                            state_d = RAMP_DN;
                        end else begin
                            // Already at the target: report arrival at once.
                            done_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end

                RAMP_UP: begin
                    if (tick_s) begin
                        duty_d = duty_up_s;
                        if (duty_up_s == tgt_q) begin
                            done_d = 1'b1;
                            if (brth_q) begin
                                tgt_d   = org_q;
                                org_d   = tgt_q;
                                state_d = RAMP_DN;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = RAMP_UP;
                        end
                    end else begin
                        state_d = RAMP_UP;
                    end
                end

                RAMP_DN: begin
                    if (tick_s) begin
                        duty_d = duty_dn_s;
                        if (duty_dn_s == tgt_q) begin
                            done_d = 1'b1;
                            if (brth_q) begin
                                tgt_d   = org_q;
                                org_d   = tgt_q;
                                state_d = RAMP_UP;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            state_d = RAMP_DN;
                        end
                    end else begin
                        state_d = RAMP_DN;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // busy is registered alongside state so it tracks state exactly.
        busy_d = (state_d != IDLE);
    end

    // FSM, latched ramp parameters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= {DUTY_W{1'b0}};
            tgt_q   <= {DUTY_W{1'b0}};
            org_q   <= {DUTY_W{1'b0}};
            div_q   <= {DIV_W{1'b0}};
            brth_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            org_q   <= org_d;
            div_q   <= div_d;
            brth_q  <= brth_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign duty = duty_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : pwm_ramp_ctrl

// File: tb/tb_pwm_ramp_ctrl.sv
`timescale 1ns/1ps

module tb_pwm_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        breathe;
    logic [3:0]  target;
    logic [15:0] step_div;
    logic [3:0]  duty;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    pwm_ramp_ctrl #(
        .DUTY_W (4),
        .DIV_W  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .breathe  (breathe),
        .target   (target),
        .step_div (step_div),
        .duty     (duty),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Present start for exactly one rising edge; returns at the falling edge after it.
    task automatic start_ramp(input logic [3:0] tgt, input logic [15:0] dv, input logic br);
        start    = 1'b1;
        target   = tgt;
        step_div = dv;
        breathe  = br;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        breathe  = 1'b0;
        target   = 4'd0;
        step_div = 16'd0;

        // 1: reset values during and after the pulse
        #2;
        check_eq("rst_duty", 32'(duty), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        #8 rst = 1'b0;
        cyc();
        check_eq("post_rst_duty", 32'(duty), 0);
        check_eq("post_rst_busy", 32'(busy), 0);
        check_eq("post_rst_done", 32'(done), 0);

        // 2: ramp 0 -> 5 at one step per edge
        start_ramp(4'd5, 16'd0, 1'b0);
        check_eq("t2_e0_duty", 32'(duty), 0);
        check_eq("t2_e0_busy", 32'(busy), 1);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check_eq("t2_duty", 32'(duty), 32'(i));
            check_eq("t2_done", 32'(done), 0);
            check_eq("t2_busy", 32'(busy), 1);
        end
        cyc();
        check_eq("t2_end_duty", 32'(duty), 5);
        check_eq("t2_end_done", 32'(done), 1);
        check_eq("t2_end_busy", 32'(busy), 0);
        cyc();
        check_eq("t2_after_done", 32'(done), 0);
        check_eq("t2_after_duty", 32'(duty), 5);

        // 3: ramp 5 -> 2 with four edges per step
        start_ramp(4'd2, 16'd3, 1'b0);
        check_eq("t3_e0_duty", 32'(duty), 5);
        check_eq("t3_e0_busy", 32'(busy), 1);
        for (int s = 0; s < 3; s++) begin
            repeat (3) begin
                cyc();
                check_eq("t3_hold_duty", 32'(duty), 32'(5 - s));
                check_eq("t3_hold_busy", 32'(busy), 1);
            end
            cyc();
            check_eq("t3_step_duty", 32'(duty), 32'(4 - s));
            check_eq("t3_step_done", 32'(done), 32'(s == 2));
            check_eq("t3_step_busy", 32'(busy), 32'(s != 2));
        end

        // back to 0 for the breathe run
        start_ramp(4'd0, 16'd0, 1'b0);
        cyc();
        check_eq("to0_duty1", 32'(duty), 1);
        cyc();
        check_eq("to0_duty0", 32'(duty), 0);
        check_eq("to0_done", 32'(done), 1);

        // 4: breathe 0..15..0..9 then abort
        start_ramp(4'd15, 16'd0, 1'b1);
        check_eq("t4_e0_busy", 32'(busy), 1);
        for (int i = 1; i <= 15; i++) begin
            cyc();
            check_eq("t4_up_duty", 32'(duty), 32'(i));
            check_eq("t4_up_done", 32'(done), 32'(i == 15));
            check_eq("t4_up_busy", 32'(busy), 1);
        end
        for (int i = 14; i >= 0; i--) begin
            cyc();
            check_eq("t4_dn_duty", 32'(duty), 32'(i));
            check_eq("t4_dn_done", 32'(done), 32'(i == 0));
            check_eq("t4_dn_busy", 32'(busy), 1);
        end
        for (int i = 1; i <= 9; i++) begin
            cyc();
            check_eq("t4_up2_duty", 32'(duty), 32'(i));
            check_eq("t4_up2_done", 32'(done), 0);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check_eq("t4_abort_duty", 32'(duty), 9);
        check_eq("t4_abort_busy", 32'(busy), 0);
        check_eq("t4_abort_done", 32'(done), 0);
        cyc();
        check_eq("t4_hold_duty", 32'(duty), 9);
        check_eq("t4_hold_busy", 32'(busy), 0);

        // 5: start with target equal to duty (7)
        start_ramp(4'd7, 16'd0, 1'b0);
        cyc();
        check_eq("to7_duty8", 32'(duty), 8);
        cyc();
        check_eq("to7_duty7", 32'(duty), 7);
        cyc();
        start_ramp(4'd7, 16'd0, 1'b0);
        check_eq("t5_busy", 32'(busy), 0);
        check_eq("t5_done", 32'(done), 1);
        check_eq("t5_duty", 32'(duty), 7);
        cyc();
        check_eq("t5_after_done", 32'(done), 0);
        check_eq("t5_after_busy", 32'(busy), 0);

        // 6a: start and abort together
        abort = 1'b1;
        start_ramp(4'd12, 16'd0, 1'b0);
        abort = 1'b0;
        check_eq("t6a_busy", 32'(busy), 0);
        check_eq("t6a_done", 32'(done), 0);
        check_eq("t6a_duty", 32'(duty), 7);
        cyc();
        check_eq("t6a_later_duty", 32'(duty), 7);
        check_eq("t6a_later_busy", 32'(busy), 0);

        // 6b: start while busy is ignored, latched values kept
        start_ramp(4'd10, 16'd1, 1'b0);
        cyc();
        check_eq("t6b_e1_duty", 32'(duty), 7);
        start    = 1'b1;
        target   = 4'd0;
        step_div = 16'd0;
        breathe  = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("t6b_e2_duty", 32'(duty), 8);
        cyc();
        check_eq("t6b_e3_duty", 32'(duty), 8);
        cyc();
        check_eq("t6b_e4_duty", 32'(duty), 9);
        cyc();
        check_eq("t6b_e5_duty", 32'(duty), 9);
        check_eq("t6b_e5_busy", 32'(busy), 1);
        cyc();
        check_eq("t6b_e6_duty", 32'(duty), 10);
        check_eq("t6b_e6_done", 32'(done), 1);
        check_eq("t6b_e6_busy", 32'(busy), 0);
        cyc();
        check_eq("t6b_e7_duty", 32'(duty), 10);
        check_eq("t6b_e7_done", 32'(done), 0);

        // 6c: reset mid-ramp clears duty without a clock edge
        start_ramp(4'd3, 16'd0, 1'b0);
        cyc();
        check_eq("t6c_duty9", 32'(duty), 9);
        cyc();
        check_eq("t6c_duty8", 32'(duty), 8);
        #2 rst = 1'b1;
        #1;
        check_eq("t6c_rst_duty", 32'(duty), 0);
        check_eq("t6c_rst_busy", 32'(busy), 0);
        check_eq("t6c_rst_done", 32'(done), 0);
        cyc();
        rst = 1'b0;
        cyc();
        check_eq("t6c_post_duty", 32'(duty), 0);
        check_eq("t6c_post_busy", 32'(busy), 0);

        // boundary: all-ones divider gives a 65536-edge step period
        start_ramp(4'd1, 16'hFFFF, 1'b0);
        repeat (65535) cyc();
        check_eq("div_max_hold_duty", 32'(duty), 0);
        check_eq("div_max_hold_busy", 32'(busy), 1);
        cyc();
        check_eq("div_max_step_duty", 32'(duty), 1);
        check_eq("div_max_step_done", 32'(done), 1);
        check_eq("div_max_step_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pwm_ramp_ctrl
